// File: rtl/my_pkg.sv
// Shared types for the fetch-stage branch target buffer: prediction record,
// direction counter type and its named states.
package my_pkg;

  localparam int BTB_TAG_W = 6;

  typedef logic [1:0] btb_ctr_t;

  localparam btb_ctr_t CTR_SNT = 2'd0;
  localparam btb_ctr_t CTR_WNT = 2'd1;
  localparam btb_ctr_t CTR_WT  = 2'd2;
  localparam btb_ctr_t CTR_ST  = 2'd3;

  typedef struct packed {
    logic                 V;
    logic [BTB_TAG_W-1:0] TAG;
    logic [31:0]          TA;
    logic                 T;
  } CACHE_BRANCH;

  // Weak and strong taken both have the upper bit set.
  function automatic logic ctr_taken(input btb_ctr_t c);
    return c[1];
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Up/down counter that saturates at zero and all-ones, with a synchronous
// load that overrides counting.
module sat_counter #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         dec,
  input  logic         load_en,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] count
);

  localparam logic [W-1:0] MAX = '1;

  // NOTE: state is updated with <= so every flop samples pre-edge values;
  // blocking here would create order-dependent races between always blocks.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load_en) begin
      count <= load_val;
    end else if (inc && !dec) begin
      if (count != MAX) count <= count + W'(1);
    end else if (dec && !inc) begin
      if (count != '0) count <= count - W'(1);
    end
  end

endmodule

// File: rtl/branch_target_buffer.sv
// Direct-mapped, run-time trained branch target buffer for the fetch stage:
// combinational lookup, registered training, flush and lookup/hit statistics.
module branch_target_buffer
  import my_pkg::*;
#(
  parameter int IDX_W = 3,
  parameter int TAG_W = BTB_TAG_W,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             lookup_en_i,
  input  logic [31:0]      lookup_pc_i,
  output CACHE_BRANCH      pred_o,
  input  logic             upd_en_i,
  input  logic [31:0]      upd_pc_i,
  input  logic             upd_taken_i,
  input  logic [31:0]      upd_target_i,
  input  logic             upd_is_jump_i,
  input  logic             flush_i,
  output logic [CNT_W-1:0] lookup_cnt_o,
  output logic [CNT_W-1:0] hit_cnt_o
);

  localparam int ENTRIES = 2 ** IDX_W;
  localparam int TAG_LSB = IDX_W + 2;

  logic [ENTRIES-1:0] valid;
  logic [ENTRIES-1:0] jump;
  logic [TAG_W-1:0]   tag_mem    [ENTRIES];
  logic [31:0]        target_mem [ENTRIES];
  btb_ctr_t           ctr        [ENTRIES];

  // Lookup side: reads registered state only, so a same-cycle update is not seen.
  logic [IDX_W-1:0] lk_idx;
  logic [TAG_W-1:0] lk_tag;
  logic             lk_hit;

  assign lk_idx = lookup_pc_i[IDX_W+1:2];
  assign lk_tag = lookup_pc_i[TAG_LSB+TAG_W-1:TAG_LSB];
  assign lk_hit = valid[lk_idx] && (tag_mem[lk_idx] == lk_tag);

  // NOTE: pred_o gets a full default before the if, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    pred_o = '0;
    if (lk_hit) begin
      pred_o.V   = 1'b1;
      pred_o.TAG = BTB_TAG_W'(tag_mem[lk_idx]);
      pred_o.TA  = target_mem[lk_idx];
      pred_o.T   = jump[lk_idx] || ctr_taken(ctr[lk_idx]);
    end
  end

  // Update side decode; a flush in the same cycle discards the update.
  logic [IDX_W-1:0] up_idx;
  logic [TAG_W-1:0] up_tag;
  logic             up_hit;
  logic             up_act;
  logic             up_alloc;
  logic             up_load;
  logic             up_inc;
  logic             up_dec;
  logic             up_write_ta;
  btb_ctr_t         up_load_val;

  assign up_idx      = upd_pc_i[IDX_W+1:2];
  assign up_tag      = upd_pc_i[TAG_LSB+TAG_W-1:TAG_LSB];
  assign up_hit      = valid[up_idx] && (tag_mem[up_idx] == up_tag);
  assign up_act      = upd_en_i && !flush_i;
  assign up_alloc    = up_act && !up_hit && (upd_taken_i || upd_is_jump_i);
  assign up_load     = up_alloc || (up_act && up_hit && upd_is_jump_i);
  assign up_inc      = up_act && up_hit && !upd_is_jump_i && upd_taken_i;
  assign up_dec      = up_act && up_hit && !upd_is_jump_i && !upd_taken_i;
  assign up_write_ta = up_load || up_inc;
  assign up_load_val = upd_is_jump_i ? CTR_ST : CTR_WT;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid <= '0;
      jump  <= '0;
    end else if (flush_i) begin
      valid <= '0;
    end else if (up_alloc) begin
      valid[up_idx] <= 1'b1;
      jump[up_idx]  <= upd_is_jump_i;
    end
  end

  // NOTE: tag and target arrays carry no reset; valid gates every read, so
  // clearing them would only add reset fan-out.
  always_ff @(posedge clk) begin
    if (up_write_ta) target_mem[up_idx] <= upd_target_i;
    if (up_alloc)    tag_mem[up_idx]    <= up_tag;
  end

  for (genvar i = 0; i < ENTRIES; i++) begin : g_ctr
    logic sel;
    assign sel = (up_idx == IDX_W'(i));

    sat_counter #(.W(2)) u_dir_ctr (
      .clk      (clk),
      .rst_n    (rst_n),
      .inc      (up_inc && sel),
      .dec      (up_dec && sel),
      .load_en  (up_load && sel),
      .load_val (up_load_val),
      .count    (ctr[i])
    );
  end

  // Statistics see the pre-flush hit and are untouched by flush.
  sat_counter #(.W(CNT_W)) u_lookup_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .inc      (lookup_en_i),
    .dec      (1'b0),
    .load_en  (1'b0),
    .load_val ('0),
    .count    (lookup_cnt_o)
  );

  sat_counter #(.W(CNT_W)) u_hit_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .inc      (lookup_en_i && lk_hit),
    .dec      (1'b0),
    .load_en  (1'b0),
    .load_val ('0),
    .count    (hit_cnt_o)
  );

  // Byte-offset bits and bits above the tag are intentionally ignored.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{lookup_pc_i[1:0], upd_pc_i[1:0],
                            lookup_pc_i >> (TAG_LSB + TAG_W),
                            upd_pc_i >> (TAG_LSB + TAG_W)};

endmodule

// File: tb/tb_branch_target_buffer.sv
// Directed bench for branch_target_buffer: allocation, counter training,
// aliasing, jumps, flush, statistics and reset priority.
module tb_branch_target_buffer;
  import my_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        lookup_en = 1'b0;
  logic [31:0] lookup_pc = '0;
  CACHE_BRANCH pred;
  logic        upd_en = 1'b0;
  logic [31:0] upd_pc = '0;
  logic        upd_taken = 1'b0;
  logic [31:0] upd_target = '0;
  logic        upd_is_jump = 1'b0;
  logic        flush = 1'b0;
  logic [15:0] lookup_cnt;
  logic [15:0] hit_cnt;

  int          total = 0;
  int          bad = 0;
  int          exp_l = 0;
  int          exp_h = 0;
  logic        cur_hit = 1'b0;
  CACHE_BRANCH exp_p;

  always #5 clk = ~clk;

  branch_target_buffer dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .lookup_en_i   (lookup_en),
    .lookup_pc_i   (lookup_pc),
    .pred_o        (pred),
    .upd_en_i      (upd_en),
    .upd_pc_i      (upd_pc),
    .upd_taken_i   (upd_taken),
    .upd_target_i  (upd_target),
    .upd_is_jump_i (upd_is_jump),
    .flush_i       (flush),
    .lookup_cnt_o  (lookup_cnt),
    .hit_cnt_o     (hit_cnt)
  );

  function automatic CACHE_BRANCH mk(input logic v, input logic [5:0] tg,
                                     input logic [31:0] ta, input logic t);
    CACHE_BRANCH p;
    p.V = v; p.TAG = tg; p.TA = ta; p.T = t;
    return p;
  endfunction

  // One clock edge; expected statistics follow the inputs driven this cycle.
  task automatic tick();
    @(posedge clk);
    if (!rst_n) begin
      exp_l = 0; exp_h = 0;
    end else if (lookup_en) begin
      exp_l++;
      if (cur_hit) exp_h++;
    end
    #1;
    lookup_en = 1'b0; upd_en = 1'b0; flush = 1'b0; cur_hit = 1'b0;
  endtask

  task automatic look(input logic [31:0] pc, input logic hit);
    lookup_en = 1'b1; lookup_pc = pc; cur_hit = hit;
    #1;
  endtask

  task automatic upd(input logic [31:0] pc, input logic taken,
                     input logic [31:0] target, input logic is_jump);
    upd_en = 1'b1; upd_pc = pc; upd_taken = taken;
    upd_target = target; upd_is_jump = is_jump;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    total++; if (lookup_cnt !== 16'd0) begin bad++; $display("FAIL reset_lookup_cnt: got %0d want 0", lookup_cnt); end
    total++; if (hit_cnt !== 16'd0) begin bad++; $display("FAIL reset_hit_cnt: got %0d want 0", hit_cnt); end
    look(32'h0040_0060, 1'b0);
    exp_p = '0;
    total++; if (pred !== exp_p) begin bad++; $display("FAIL reset_pred: got %h want %h", pred, exp_p); end
    tick();
    for (int i = 0; i < 4; i++) begin look(32'h0040_0060, 1'b0); tick(); end
    total++; if (lookup_cnt !== 16'd5) begin bad++; $display("FAIL five_lookups: got %0d want 5", lookup_cnt); end
    total++; if (hit_cnt !== 16'd0) begin bad++; $display("FAIL five_no_hits: got %0d want 0", hit_cnt); end
  endtask

  task automatic test_allocate();
    upd(32'h0040_0060, 1'b1, 32'h0040_008c, 1'b0); tick();
    look(32'h0040_0060, 1'b1);
    exp_p = mk(1'b1, 6'h03, 32'h0040_008c, 1'b1);
    total++; if (pred !== exp_p) begin bad++; $display("FAIL alloc_hit: got %h want %h", pred, exp_p); end
    tick();
  endtask

  task automatic test_counter();
    // 2 -> 1 -> 0
    for (int i = 0; i < 2; i++) begin upd(32'h0040_0060, 1'b0, 32'h0040_0abc, 1'b0); tick(); end
    look(32'h0040_0060, 1'b1);
    exp_p = mk(1'b1, 6'h03, 32'h0040_008c, 1'b0);
    total++; if (pred !== exp_p) begin bad++; $display("FAIL not_taken_twice: got %h want %h", pred, exp_p); end
    tick();
    // 0 -> 1 -> 2 -> 3, then a fourth taken must hold at 3 and retarget
    for (int i = 0; i < 3; i++) begin upd(32'h0040_0060, 1'b1, 32'h0040_008c, 1'b0); tick(); end
    upd(32'h0040_0060, 1'b1, 32'h0040_0100, 1'b0); tick();
    look(32'h0040_0060, 1'b1);
    exp_p = mk(1'b1, 6'h03, 32'h0040_0100, 1'b1);
    total++; if (pred !== exp_p) begin bad++; $display("FAIL taken_four: got %h want %h", pred, exp_p); end
    tick();
    upd(32'h0040_0060, 1'b0, 32'h0040_0abc, 1'b0); tick();
    look(32'h0040_0060, 1'b1);
    total++; if (pred !== exp_p) begin bad++; $display("FAIL sat_then_nt: got %h want %h", pred, exp_p); end
    tick();
    upd(32'h0040_0060, 1'b0, 32'h0040_0abc, 1'b0); tick();
    look(32'h0040_0060, 1'b1);
    exp_p = mk(1'b1, 6'h03, 32'h0040_0100, 1'b0);
    total++; if (pred !== exp_p) begin bad++; $display("FAIL sat_then_nt2: got %h want %h", pred, exp_p); end
    tick();
  endtask

  task automatic test_alias();
    look(32'h0040_0460, 1'b0);
    exp_p = '0;
    total++; if (pred !== exp_p) begin bad++; $display("FAIL alias_miss: got %h want %h", pred, exp_p); end
    tick();
    upd(32'h0040_0460, 1'b1, 32'h0040_0034, 1'b0); tick();
    look(32'h0040_0060, 1'b0);
    total++; if (pred !== exp_p) begin bad++; $display("FAIL alias_evicted: got %h want %h", pred, exp_p); end
    tick();
    look(32'h0040_0460, 1'b1);
    exp_p = mk(1'b1, 6'h23, 32'h0040_0034, 1'b1);
    total++; if (pred !== exp_p) begin bad++; $display("FAIL alias_new: got %h want %h", pred, exp_p); end
    tick();
    upd(32'h0040_0078, 1'b0, 32'h0040_0200, 1'b0); tick();
    look(32'h0040_0078, 1'b0);
    exp_p = '0;
    total++; if (pred !== exp_p) begin bad++; $display("FAIL miss_not_taken: got %h want %h", pred, exp_p); end
    tick();
  endtask

  task automatic test_jump();
    upd(32'h0040_0014, 1'b1, 32'h0040_001c, 1'b1);
    look(32'h0040_0014, 1'b0);
    exp_p = '0;
    total++; if (pred !== exp_p) begin bad++; $display("FAIL jump_same_cycle: got %h want %h", pred, exp_p); end
    tick();
    look(32'h0040_0014, 1'b1);
    exp_p = mk(1'b1, 6'h00, 32'h0040_001c, 1'b1);
    total++; if (pred !== exp_p) begin bad++; $display("FAIL jump_next: got %h want %h", pred, exp_p); end
    tick();
    upd(32'h0040_0014, 1'b0, 32'h0040_0999, 1'b0); tick();
    look(32'h0040_0014, 1'b1);
    total++; if (pred !== exp_p) begin bad++; $display("FAIL jump_nt1: got %h want %h", pred, exp_p); end
    tick();
    upd(32'h0040_0014, 1'b0, 32'h0040_0999, 1'b0); tick();
    look(32'h0040_0014, 1'b1);
    total++; if (pred !== exp_p) begin bad++; $display("FAIL jump_nt2: got %h want %h", pred, exp_p); end
    tick();
    look(32'h0040_0017, 1'b1);
    total++; if (pred !== exp_p) begin bad++; $display("FAIL low_bits_ignored: got %h want %h", pred, exp_p); end
    tick();
  endtask

  task automatic test_flush();
    flush = 1'b1;
    upd(32'h0040_0094, 1'b1, 32'h0040_0200, 1'b0);
    look(32'h0040_0014, 1'b1);
    exp_p = mk(1'b1, 6'h00, 32'h0040_001c, 1'b1);
    total++; if (pred !== exp_p) begin bad++; $display("FAIL flush_cycle_hit: got %h want %h", pred, exp_p); end
    tick();
    exp_p = '0;
    look(32'h0040_0014, 1'b0);
    total++; if (pred !== exp_p) begin bad++; $display("FAIL flush_idx5: got %h want %h", pred, exp_p); end
    tick();
    look(32'h0040_0460, 1'b0);
    total++; if (pred !== exp_p) begin bad++; $display("FAIL flush_idx0: got %h want %h", pred, exp_p); end
    tick();
    look(32'h0040_0094, 1'b0);
    total++; if (pred !== exp_p) begin bad++; $display("FAIL flush_upd_dropped: got %h want %h", pred, exp_p); end
    tick();
    total++; if (lookup_cnt !== 16'(exp_l)) begin bad++; $display("FAIL flush_lookup_cnt: got %0d want %0d", lookup_cnt, exp_l); end
    total++; if (hit_cnt !== 16'(exp_h)) begin bad++; $display("FAIL flush_hit_cnt: got %0d want %0d", hit_cnt, exp_h); end
  endtask

  task automatic test_reset_mid();
    upd(32'h0040_0060, 1'b1, 32'h0040_008c, 1'b0); tick();
    look(32'h0040_0060, 1'b1);
    exp_p = mk(1'b1, 6'h03, 32'h0040_008c, 1'b1);
    total++; if (pred !== exp_p) begin bad++; $display("FAIL pre_reset_hit: got %h want %h", pred, exp_p); end
    rst_n = 1'b0; flush = 1'b1;
    upd(32'h0040_0014, 1'b1, 32'h0040_001c, 1'b1);
    tick();
    rst_n = 1'b1;
    total++; if (lookup_cnt !== 16'd0) begin bad++; $display("FAIL mid_reset_lookup_cnt: got %0d want 0", lookup_cnt); end
    total++; if (hit_cnt !== 16'd0) begin bad++; $display("FAIL mid_reset_hit_cnt: got %0d want 0", hit_cnt); end
    exp_p = '0;
    look(32'h0040_0060, 1'b0);
    total++; if (pred !== exp_p) begin bad++; $display("FAIL mid_reset_cleared: got %h want %h", pred, exp_p); end
    tick();
    look(32'h0040_0014, 1'b0);
    total++; if (pred !== exp_p) begin bad++; $display("FAIL reset_beats_update: got %h want %h", pred, exp_p); end
    tick();
    total++; if (lookup_cnt !== 16'd2) begin bad++; $display("FAIL post_reset_lookup_cnt: got %0d want 2", lookup_cnt); end
    total++; if (hit_cnt !== 16'd0) begin bad++; $display("FAIL post_reset_hit_cnt: got %0d want 0", hit_cnt); end
  endtask

  initial begin
    test_reset();
    test_allocate();
    test_counter();
    test_alias();
    test_jump();
    test_flush();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/branch_target_buffer.md
Name: branch_target_buffer

Overview:
- Writable, direct-mapped branch target buffer (BTB) for the fetch stage of the RISCV-Lite core.
- Replaces the fixed, hardwired branch lookup table with a parametrised table that is trained at run time by the execute stage.
- Each entry stores a valid bit, tag, target address, 2-bit saturating direction counter and jump flag.
- Lookup is combinational on the fetch PC. Updates, flush and statistics counters are sequential.

Parameters:
- IDX_W, 3: index width; ENTRIES = 2**IDX_W; index = pc[IDX_W+1:2].
- TAG_W, 6: tag width; tag = pc[IDX_W+TAG_W+1:IDX_W+2].
- CNT_W, 16: width of the saturating hit and lookup statistics counters.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst_n  in  1  synchronous active-low reset.
- lookup_en_i  in  1  fetch issues a lookup this cycle (used for statistics only).
- lookup_pc_i  in  32  fetch PC.
- pred_o  out  CACHE_BRANCH  prediction: V=hit, TAG=stored tag, TA=target, T=predict taken.
- upd_en_i  in  1  resolved control-flow instruction from execute.
- upd_pc_i  in  32  PC of the resolved instruction.
- upd_taken_i  in  1  actual outcome.
- upd_target_i  in  32  actual target.
- upd_is_jump_i  in  1  unconditional jal/jalr.
- flush_i  in  1  invalidate all entries.
- lookup_cnt_o  out  CNT_W  number of cycles with lookup_en_i=1.
- hit_cnt_o  out  CNT_W  number of lookups that hit.

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - All valid bits, counters and jump flags are cleared to 0.
  - Tags and targets need not be reset.
  - lookup_cnt_o = 0 and hit_cnt_o = 0.
  - Reset takes priority over flush and update in the same cycle.
- Lookup (combinational, 0-cycle latency, reads registered state only):
  - hit = valid[idx] && tag[idx] == lookup tag.
  - pred_o.V = hit.
  - pred_o.T = hit && (jump[idx] || ctr[idx][1]).
  - pred_o.TA = hit ? target[idx] : 0.
  - pred_o.TAG = hit ? tag[idx] : 0.
  - With no hit, all pred_o fields are 0.
- Update (registered; visible to lookups from the next cycle onward). Cases, with upd_en_i=1:
  - Hit, jump: target is written and the counter is forced to 2'b11.
  - Hit, branch, taken: counter = min(ctr+1, 3); target is written.
  - Hit, branch, not taken: counter = max(ctr-1, 0); target is kept; entry stays valid.
  - Miss, taken (or jump): allocate the entry, overwriting any alias. Set valid=1 and write tag and target. Counter = 2'b11 if jump, else 2'b10. jump = upd_is_jump_i.
  - Miss, not taken: no change.
- Same-cycle update and lookup to the same index: the lookup returns the old contents. There is no forwarding.
- flush_i=1: all valid bits are cleared at the edge. A simultaneous update is discarded (flush wins). Statistics counters are not affected by flush.
- Statistics:
  - lookup_cnt_o increments when lookup_en_i=1.
  - hit_cnt_o increments when lookup_en_i && hit.
  - Both saturate at 2**CNT_W-1 and never wrap.
  - Both still count during a flush cycle, using the pre-flush hit.
- PC bits [1:0] are ignored. PC bits above IDX_W+TAG_W+1 are not compared, so aliasing on those bits is accepted.

Decomposition:
- my_pkg holds:
  - CACHE_BRANCH, generalised to a TAG_W-wide TAG. Package constant BTB_TAG_W = 6 is the default, so existing users remain compatible.
  - typedef btb_ctr_t as logic [1:0].
  - Counter constants CTR_SNT=0, CTR_WNT=1, CTR_WT=2, CTR_ST=3.
- Sub-module sat_counter (parametrised width; inc/dec/force inputs; saturating) is used for the per-entry direction counters and both statistics counters.
- Entry storage lives in flops inside branch_target_buffer (no SRAM macro).

Test Plan:
- Reset then lookup_pc_i=0x400060 -> pred_o all zero; after 5 lookups, lookup_cnt_o=5 and hit_cnt_o=0.
- Update pc=0x400060, taken=1, target=0x40008c, jump=0; next cycle lookup 0x400060 -> V=1, TAG=6'b000011, TA=0x40008c, T=1.
- Two further not-taken updates at 0x400060 -> V=1, T=0, TA still 0x40008c. Then three taken updates -> T=1, and the counter saturates at 3.
- Alias: lookup 0x400460 (same index 0, tag 0x23) -> V=0. Taken update at 0x400460 with target 0x400034 replaces the entry, after which lookup 0x400060 -> V=0.
- Jump update pc=0x400014, target=0x40001c, jump=1 in the same cycle as lookup 0x400014 -> that cycle V=0; next cycle V=1, T=1. One not-taken update leaves T=1.
- flush_i=1 with a simultaneous update to 0x400094 -> next cycle every lookup gives V=0 and statistics are retained. Drive rst_n=0 mid-sequence -> counters are 0 on the next edge.
